// File: rtl/gprs_wrport_arb_if.sv
// Bundle between the retire / long-latency return producers and the GPR write-port arbiter.
// master: producer side (retire stream, lr return stream, GPR file observer).
// slave:  the arbiter.
interface gprs_wrport_arb_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Retire write stream (no backpressure)
    logic            wren_rb0;
    logic [AW-1:0]   wraddr_rb0;
    logic [XLEN-1:0] wrdata_rb0;

    // Long-latency return stream
    logic            lr_valid;
    logic            lr_ready;
    logic [AW-1:0]   lr_addr;
    logic [XLEN-1:0] lr_data;

    // Registered GPR write port and status
    logic            wren_gp;
    logic [AW-1:0]   wraddr_gp;
    logic [XLEN-1:0] wrdata_gp;
    logic            stall_req;
    logic [CW-1:0]   lr_cnt;

    modport master (
        output wren_rb0, wraddr_rb0, wrdata_rb0,
        output lr_valid, lr_addr, lr_data,
        input  lr_ready,
        input  wren_gp, wraddr_gp, wrdata_gp, stall_req, lr_cnt
    );

    modport slave (
        input  wren_rb0, wraddr_rb0, wrdata_rb0,
        input  lr_valid, lr_addr, lr_data,
        output lr_ready,
        output wren_gp, wraddr_gp, wrdata_gp, stall_req, lr_cnt
    );
endinterface

// File: rtl/gprs_wrport_arb.sv
// GPR write-port arbiter: retire writes always win; long-latency returns queue in a small
// FIFO and drain into idle port cycles. A starvation counter raises stall_req so the
// scoreboard inserts a retire bubble and the queue cannot be starved forever.
// Optional feature: define GPRWR_WAW_SQUASH_EN to drop queued returns made stale by a
// younger retire write to the same register.
module gprs_wrport_arb #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5
) (
    input logic               clk,
    input logic               reset,
    gprs_wrport_arb_if.slave  port_io
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]   fifo_addr_q [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [7:0]      starve_q, starve_d;
    logic            stall_q, stall_d;
    logic            ready_en_q;
    logic            wren_q;
    logic [AW-1:0]   wraddr_q;
    logic [XLEN-1:0] wrdata_q;

    logic retire_req, lr_ready, push, pop, fifo_empty, head_live, lr_write;

    // Writes to x0 never reach the port
    assign retire_req = port_io.wren_rb0 && (port_io.wraddr_rb0 != '0);
    assign fifo_empty = (cnt_q == '0);
    // ready_en_q keeps lr_ready low through reset and releases it one edge later
    assign lr_ready   = ready_en_q && (cnt_q < CW'(DEPTH));
    // x0 returns are accepted but dropped on the floor
    assign push       = port_io.lr_valid && lr_ready && (port_io.lr_addr != '0);

`ifdef GPRWR_WAW_SQUASH_EN
    logic [DEPTH-1:0] live_q, live_d;

    assign head_live = live_q[rd_ptr_q];
    // A dead head leaves even under a retire grant, so it never costs a port cycle
    assign pop       = !fifo_empty && (!head_live || !retire_req);

    // Invalidate queued entries overwritten by the granted retire write
    always_comb begin
        live_d = live_q;
        if (retire_req) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (fifo_addr_q[i] == port_io.wraddr_rb0) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        // A same-cycle return is older than the retire write
        if (push) begin
            live_d[wr_ptr_q] = !(retire_req && (port_io.lr_addr == port_io.wraddr_rb0));
        end
    end

    // Per-entry live flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q <= '0;
        end else begin
            live_q <= live_d;
        end
    end
`else
    assign head_live = 1'b1;
    assign pop       = !fifo_empty && !retire_req;
`endif

    assign lr_write = pop && head_live && !retire_req;

    // Occupancy, starvation counter and bubble request next state
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q < StarveMax) begin
            starve_d = starve_q + 8'd1;
        end

        stall_d = stall_q;
        if (fifo_empty || pop) begin
            stall_d = 1'b0;
        end else if (starve_d == StarveMax) begin
            stall_d = 1'b1;
        end
    end

    // FIFO storage, pointers, counters and the registered write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            ready_en_q <= 1'b0;
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            ready_en_q <= 1'b1;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;

            if (push) begin
                fifo_addr_q[wr_ptr_q] <= port_io.lr_addr;
                fifo_data_q[wr_ptr_q] <= port_io.lr_data;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            // Address/data hold their last value on idle cycles
            if (retire_req) begin
                wren_q   <= 1'b1;
                wraddr_q <= port_io.wraddr_rb0;
                wrdata_q <= port_io.wrdata_rb0;
            end else if (lr_write) begin
                wren_q   <= 1'b1;
                wraddr_q <= fifo_addr_q[rd_ptr_q];
                wrdata_q <= fifo_data_q[rd_ptr_q];
            end else begin
                wren_q   <= 1'b0;
            end
        end
    end

    assign port_io.lr_ready  = lr_ready;
    assign port_io.wren_gp   = wren_q;
    assign port_io.wraddr_gp = wraddr_q;
    assign port_io.wrdata_gp = wrdata_q;
    assign port_io.stall_req = stall_q;
    assign port_io.lr_cnt    = cnt_q;

endmodule

// File: tb/tb_gprs_wrport_arb.sv
// Bench for gprs_wrport_arb: expected GPR writes (cycle, address, data) are queued as stimulus
// is driven and compared against the writes seen on the port. Builds with or without
// GPRWR_WAW_SQUASH_EN.
module tb_gprs_wrport_arb;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 8;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned AW         = 5;

    typedef struct packed {
        logic [15:0]     cyc;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    gprs_wrport_arb_if #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) bus ();

    gprs_wrport_arb #(
        .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .XLEN(XLEN), .AW(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .port_io(bus)
    );

    always #5 clk = ~clk;

    int cyc;
    int n_checks;
    int n_fail;
    wr_t sbq[$];
    wr_t obs[$];
    logic [XLEN-1:0] regf [32];

    // Advance one cycle: sample the write port mid-cycle, return #1 after the next edge
    task automatic tick();
        wr_t w;
        @(negedge clk);
        if (bus.wren_gp === 1'b1) begin
            w.cyc  = 16'(cyc);
            w.addr = bus.wraddr_gp;
            w.data = bus.wrdata_gp;
            obs.push_back(w);
            regf[bus.wraddr_gp] = bus.wrdata_gp;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic expect_wr(input int c, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_t w;
        w.cyc  = 16'(c);
        w.addr = a;
        w.data = d;
        sbq.push_back(w);
    endtask

    task automatic idle_inputs();
        bus.wren_rb0   = 1'b0;
        bus.wraddr_rb0 = '0;
        bus.wrdata_rb0 = '0;
        bus.lr_valid   = 1'b0;
        bus.lr_addr    = '0;
        bus.lr_data    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.wren_gp, bus.wraddr_gp, bus.wrdata_gp, bus.stall_req} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wren=%b addr=%0d data=%h stall=%b, required all 0",
                     bus.wren_gp, bus.wraddr_gp, bus.wrdata_gp, bus.stall_req);
        end
        n_checks++;
        if (bus.lr_cnt !== 3'd0 || bus.lr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo: got lr_cnt=%0d lr_ready=%b, required 0 0",
                     bus.lr_cnt, bus.lr_ready);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus.lr_ready !== 1'b1 || bus.lr_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: got lr_ready=%b lr_cnt=%0d, required 1 0",
                     bus.lr_ready, bus.lr_cnt);
        end
    endtask

    task automatic test_retire();
        int n;
        wr_t e, o;
        n = cyc;
        bus.wren_rb0 = 1'b1; bus.wraddr_rb0 = 5'd7; bus.wrdata_rb0 = 32'hDEAD_BEEF;
        expect_wr(n + 1, 5'd7, 32'hDEAD_BEEF);
        tick();
        bus.wren_rb0 = 1'b0;
        tick();
        tick();
        n = cyc;
        for (int i = 0; i < 3; i++) begin
            bus.wren_rb0   = 1'b1;
            bus.wraddr_rb0 = 5'(17 + i);
            bus.wrdata_rb0 = $urandom;
            expect_wr(n + i + 1, bus.wraddr_rb0, bus.wrdata_rb0);
            tick();
        end
        idle_inputs();
        tick();
        tick();
        while (sbq.size() != 0 || obs.size() != 0) begin
            n_checks++;
            if (obs.size() == 0) begin
                e = sbq.pop_front(); n_fail++;
                $display("FAIL retire_write: got no write, required cyc=%0d addr=%0d data=%h",
                         e.cyc, e.addr, e.data);
            end else if (sbq.size() == 0) begin
                o = obs.pop_front(); n_fail++;
                $display("FAIL retire_write: got cyc=%0d addr=%0d data=%h, required no write",
                         o.cyc, o.addr, o.data);
            end else begin
                e = sbq.pop_front(); o = obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL retire_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_lr_drain();
        int n;
        wr_t e, o;
        n = cyc;
        for (int i = 0; i < 3; i++) begin
            bus.lr_valid = 1'b1;
            bus.lr_addr  = 5'(3 + i);
            bus.lr_data  = $urandom;
            n_checks++;
            if (bus.lr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_ready: got lr_ready=%b, required 1", bus.lr_ready);
            end
            expect_wr(n + i + 2, bus.lr_addr, bus.lr_data);
            tick();
            n_checks++;
            if (bus.lr_cnt !== 3'd1) begin
                n_fail++;
                $display("FAIL drain_cnt: got lr_cnt=%0d, required 1", bus.lr_cnt);
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (bus.lr_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: got lr_cnt=%0d, required 0", bus.lr_cnt);
        end
        tick();
        tick();
        while (sbq.size() != 0 || obs.size() != 0) begin
            n_checks++;
            if (obs.size() == 0) begin
                e = sbq.pop_front(); n_fail++;
                $display("FAIL drain_write: got no write, required cyc=%0d addr=%0d data=%h",
                         e.cyc, e.addr, e.data);
            end else if (sbq.size() == 0) begin
                o = obs.pop_front(); n_fail++;
                $display("FAIL drain_write: got cyc=%0d addr=%0d data=%h, required no write",
                         o.cyc, o.addr, o.data);
            end else begin
                e = sbq.pop_front(); o = obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL drain_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_full();
        int n, m, idx;
        wr_t e, o;
        n = cyc;
        for (int k = 0; k < 6; k++) begin
            idx = (k < 4) ? k : 4;
            bus.wren_rb0   = 1'b1;
            bus.wraddr_rb0 = 5'(20 + k);
            bus.wrdata_rb0 = $urandom;
            expect_wr(n + k + 1, bus.wraddr_rb0, bus.wrdata_rb0);
            bus.lr_valid   = 1'b1;
            bus.lr_addr    = 5'(10 + idx);
            bus.lr_data    = 32'h1000 + 32'(idx);
            n_checks++;
            if (bus.lr_ready !== (k < 4)) begin
                n_fail++;
                $display("FAIL full_ready: got lr_ready=%b at offer %0d, required %b",
                         bus.lr_ready, k, (k < 4));
            end
            tick();
        end
        m = cyc;
        bus.wren_rb0 = 1'b0;
        n_checks++;
        if (bus.lr_ready !== 1'b0 || bus.lr_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got lr_ready=%b lr_cnt=%0d, required 0 4",
                     bus.lr_ready, bus.lr_cnt);
        end
        tick();
        n_checks++;
        if (bus.lr_ready !== 1'b1 || bus.lr_cnt !== 3'd3) begin
            n_fail++;
            $display("FAIL full_reopen: got lr_ready=%b lr_cnt=%0d, required 1 3",
                     bus.lr_ready, bus.lr_cnt);
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            expect_wr(m + i + 1, 5'(10 + i), 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 6; i++) tick();
        while (sbq.size() != 0 || obs.size() != 0) begin
            n_checks++;
            if (obs.size() == 0) begin
                e = sbq.pop_front(); n_fail++;
                $display("FAIL full_write: got no write, required cyc=%0d addr=%0d data=%h",
                         e.cyc, e.addr, e.data);
            end else if (sbq.size() == 0) begin
                o = obs.pop_front(); n_fail++;
                $display("FAIL full_write: got cyc=%0d addr=%0d data=%h, required no write",
                         o.cyc, o.addr, o.data);
            end else begin
                e = sbq.pop_front(); o = obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL full_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int n;
        logic exp_stall;
        wr_t e, o;
        n = cyc;
        bus.lr_valid = 1'b1;
        bus.lr_addr  = 5'd6;
        bus.lr_data  = 32'h6666_0006;
        for (int k = 0; k <= 13; k++) begin
            exp_stall = (k >= 9) && (k <= 12);
            n_checks++;
            if (bus.stall_req !== exp_stall) begin
                n_fail++;
                $display("FAIL starve_stall: got stall_req=%b at cycle +%0d, required %b",
                         bus.stall_req, k, exp_stall);
            end
            if (k < 12) begin
                bus.wren_rb0   = 1'b1;
                bus.wraddr_rb0 = 5'd1;
                bus.wrdata_rb0 = 32'h100 + 32'(k);
                expect_wr(n + k + 1, 5'd1, bus.wrdata_rb0);
            end else begin
                bus.wren_rb0 = 1'b0;
            end
            tick();
            if (k == 0) bus.lr_valid = 1'b0;
        end
        expect_wr(n + 13, 5'd6, 32'h6666_0006);
        idle_inputs();
        tick();
        n_checks++;
        if (bus.lr_cnt !== 3'd0 || bus.stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_end: got lr_cnt=%0d stall_req=%b, required 0 0",
                     bus.lr_cnt, bus.stall_req);
        end
        while (sbq.size() != 0 || obs.size() != 0) begin
            n_checks++;
            if (obs.size() == 0) begin
                e = sbq.pop_front(); n_fail++;
                $display("FAIL starve_write: got no write, required cyc=%0d addr=%0d data=%h",
                         e.cyc, e.addr, e.data);
            end else if (sbq.size() == 0) begin
                o = obs.pop_front(); n_fail++;
                $display("FAIL starve_write: got cyc=%0d addr=%0d data=%h, required no write",
                         o.cyc, o.addr, o.data);
            end else begin
                e = sbq.pop_front(); o = obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL starve_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_waw();
        int n;
        logic [XLEN-1:0] exp_r9;
        wr_t e, o;
        // Return queued behind a retire write, then overwritten by a younger retire write
        n = cyc;
        bus.wren_rb0 = 1'b1; bus.wraddr_rb0 = 5'd1; bus.wrdata_rb0 = 32'h11;
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd9; bus.lr_data = 32'hAAAA_0009;
        expect_wr(n + 1, 5'd1, 32'h11);
        tick();
        bus.lr_valid = 1'b0;
        bus.wraddr_rb0 = 5'd9; bus.wrdata_rb0 = 32'h1;
        expect_wr(n + 2, 5'd9, 32'h1);
        tick();
        idle_inputs();
`ifdef GPRWR_WAW_SQUASH_EN
        exp_r9 = 32'h1;
`else
        exp_r9 = 32'hAAAA_0009;
        expect_wr(n + 3, 5'd9, 32'hAAAA_0009);
`endif
        tick();
        n_checks++;
        if (bus.lr_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL waw_cnt: got lr_cnt=%0d, required 0", bus.lr_cnt);
        end
        tick();
        n_checks++;
        if (regf[9] !== exp_r9) begin
            n_fail++;
            $display("FAIL waw_r9: got r9=%h, required %h", regf[9], exp_r9);
        end
        // Retire and return to the same register in the same cycle: the return is older
        n = cyc;
        bus.wren_rb0 = 1'b1; bus.wraddr_rb0 = 5'd9; bus.wrdata_rb0 = 32'h2;
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd9; bus.lr_data = 32'hBBBB_0009;
        expect_wr(n + 1, 5'd9, 32'h2);
`ifdef GPRWR_WAW_SQUASH_EN
        exp_r9 = 32'h2;
`else
        exp_r9 = 32'hBBBB_0009;
        expect_wr(n + 2, 5'd9, 32'hBBBB_0009);
`endif
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        n_checks++;
        if (regf[9] !== exp_r9 || bus.lr_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL waw_same_cycle: got r9=%h lr_cnt=%0d, required %h 0",
                     regf[9], bus.lr_cnt, exp_r9);
        end
        while (sbq.size() != 0 || obs.size() != 0) begin
            n_checks++;
            if (obs.size() == 0) begin
                e = sbq.pop_front(); n_fail++;
                $display("FAIL waw_write: got no write, required cyc=%0d addr=%0d data=%h",
                         e.cyc, e.addr, e.data);
            end else if (sbq.size() == 0) begin
                o = obs.pop_front(); n_fail++;
                $display("FAIL waw_write: got cyc=%0d addr=%0d data=%h, required no write",
                         o.cyc, o.addr, o.data);
            end else begin
                e = sbq.pop_front(); o = obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL waw_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_x0_reset();
        int n;
        wr_t e, o;
        // Both streams target x0: nothing is queued or written
        bus.wren_rb0 = 1'b1; bus.wraddr_rb0 = 5'd0; bus.wrdata_rb0 = 32'hFFFF_FFFF;
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd0; bus.lr_data = 32'hEEEE_EEEE;
        n_checks++;
        if (bus.lr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready: got lr_ready=%b, required 1", bus.lr_ready);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (bus.lr_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL x0_discard: got lr_cnt=%0d, required 0", bus.lr_cnt);
        end
        tick();
        tick();
        // Queue two returns behind retire traffic, then reset
        n = cyc;
        bus.wren_rb0 = 1'b1; bus.wraddr_rb0 = 5'd2; bus.wrdata_rb0 = 32'h22;
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd15; bus.lr_data = 32'h15;
        expect_wr(n + 1, 5'd2, 32'h22);
        tick();
        bus.wrdata_rb0 = 32'h23;
        bus.lr_addr = 5'd16; bus.lr_data = 32'h16;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.lr_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_queued: got lr_cnt=%0d, required 2", bus.lr_cnt);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.wren_gp, bus.wraddr_gp, bus.wrdata_gp, bus.stall_req, bus.lr_cnt, bus.lr_ready}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got wren=%b addr=%0d data=%h stall=%b cnt=%0d ready=%b, required all 0",
                     bus.wren_gp, bus.wraddr_gp, bus.wrdata_gp, bus.stall_req, bus.lr_cnt,
                     bus.lr_ready);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (bus.lr_cnt !== 3'd0 || bus.lr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_after: got lr_cnt=%0d lr_ready=%b, required 0 1",
                     bus.lr_cnt, bus.lr_ready);
        end
        while (sbq.size() != 0 || obs.size() != 0) begin
            n_checks++;
            if (obs.size() == 0) begin
                e = sbq.pop_front(); n_fail++;
                $display("FAIL x0_reset_write: got no write, required cyc=%0d addr=%0d data=%h",
                         e.cyc, e.addr, e.data);
            end else if (sbq.size() == 0) begin
                o = obs.pop_front(); n_fail++;
                $display("FAIL x0_reset_write: got cyc=%0d addr=%0d data=%h, required no write",
                         o.cyc, o.addr, o.data);
            end else begin
                e = sbq.pop_front(); o = obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL x0_reset_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) regf[i] = '0;
        test_reset();
        test_retire();
        test_lr_drain();
        test_full();
        test_starvation();
        test_waw();
        test_x0_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gprs_wrport_arb.md
# gprs_wrport_arb

Write-port arbiter and scheduler for the single GPR write port. It merges the in-order retire write stream (rb0) with an out-of-order long-latency return stream (lr: multi-cycle divider or load fill) onto one registered write port into the GPR file. Retire always has priority. Long-latency returns wait in a small FIFO. A starvation counter asks the scoreboard for a bubble so queued returns always drain.

## Interface
- `DEPTH`, default 4: lr FIFO entries; power of 2, minimum 2.
- `STARVE_MAX`, default 8: consecutive denied cycles before a bubble is requested; range 1..255.
- `XLEN`, default 32: register data width.
- `AW`, default 5: register address width.

- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-low reset.
- `wren_rb0` in 1: retire write valid. There is no backpressure on this input.
- `wraddr_rb0` in AW: retire destination register.
- `wrdata_rb0` in XLEN: retire write data.
- `lr_valid` in 1: long-latency return valid.
- `lr_ready` out 1: FIFO can accept a return.
- `lr_addr` in AW: return destination register.
- `lr_data` in XLEN: return data.
- `wren_gp` out 1: registered write enable to the GPR file.
- `wraddr_gp` out AW: registered write address.
- `wrdata_gp` out XLEN: registered write data.
- `stall_req` out 1: requests a retire bubble from the scoreboard.
- `lr_cnt` out $clog2(DEPTH)+1: live FIFO occupancy.

## Operation
- **Accept:**
  - An lr return is accepted when `lr_valid & lr_ready`.
  - `lr_ready = (cnt < DEPTH)`. It is computed from the registered count only, with no same-cycle pop forwarding.
- **x0 filtering:**
  - A retire write with `wraddr_rb0 == 0` is treated as no request.
  - An accepted lr with `lr_addr == 0` is consumed and discarded, never enqueued.
- **Grant each cycle:**
  - A retire request (valid, address not 0) wins the port.
  - Otherwise, if the FIFO is non-empty, the head is popped and written.
  - Otherwise, no write is issued.
- **Ordering:**
  - A return accepted in cycle N is never written before cycle N+2.
  - There is no bypass around the FIFO.
- **Push and pop:**
  - Push and pop may occur in the same cycle.
  - `cnt` then holds; the pointers wrap modulo DEPTH.
- **Starvation counter (8 bits):**
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- **stall_req:**
  - Registered.
  - Set the cycle after the counter reaches STARVE_MAX.
  - Held until the cycle after the head pops.
- **Retire overlap:** if retire writes in the same cycle that the head would have popped, the head simply waits.

## Timing
- **Reset values:**
  - `wren_gp=0`, `wraddr_gp=0`, `wrdata_gp=0`, `stall_req=0`, `lr_cnt=0`.
  - `lr_ready=0` while `reset` is low, then 1 on the first cycle after release.
  - The FIFO and all pointers are cleared.
- **Reset mid-operation:** queued returns are lost without being written; upstream reissue is the owner's responsibility.
- **Retire latency:** `wren_rb0` in cycle N gives `wren_gp` in cycle N+1 with identical address and data.
- **lr latency:** minimum two cycles, accept to `wren_gp`.
- **Full FIFO:**
  - `lr_ready` is low for the whole cycle.
  - A pop in that cycle raises `lr_ready` in the next cycle.
- **`lr_cnt`:** updates on the edge following the push or pop.

## Configuration
- **`GPRWR_WAW_SQUASH_EN` defined:**
  - A granted retire write to address A invalidates every live FIFO entry with address A.
  - This includes an lr accepted in the same cycle, which is defined as older.
  - A dead head is popped with no write.
  - Dead-head pops may coincide with a retire grant, so squashed entries never consume port cycles.
  - `lr_cnt` counts dead entries until they pop.
- **Not defined:**
  - No squash logic.
  - All enqueued entries are written in FIFO order, regardless of later retire writes to the same register.

## Test plan
- **Retire passthrough:** `wren_rb0=1`, addr 7, data 0xDEAD_BEEF in cycle 10 → `wren_gp=1`, addr 7, data 0xDEADBEEF in cycle 11; no write in cycle 12.
- **lr queue drain:** 3 lr returns (addrs 3/4/5) in back-to-back cycles with retire idle → writes to 3, 4, 5 in cycles N+2, N+3, N+4; `lr_cnt` peaks at 1; `lr_ready` stays 1.
- **Full FIFO:** retire busy every cycle, 5 lr offers (DEPTH=4) → the 5th sees `lr_ready=0`. `lr_ready` stays low until the cycle after retire goes idle and one entry pops.
- **Starvation:** 1 queued lr, retire continuous, STARVE_MAX=8 → `stall_req` rises after 8 denied cycles. A bubble pops the head, and `stall_req` falls one cycle later.
- **WAW squash (`GPRWR_WAW_SQUASH_EN`):** lr addr 9 queued, retire writes addr 9 with data 0x1 → the lr is never written; r9 final value is 0x1; `lr_cnt` returns to 0. With the macro undefined, r9 is written by the lr afterwards.
- **x0 and reset:** lr and retire writes to addr 0 → no `wren_gp`. Assert `reset` low with 2 entries queued → all outputs 0, `lr_cnt=0`, no writes after release.
